crtc_config_seq: RTL and testbench
==================================

# crtc_config_seq

Bus-master sequencer that programs the MS6845 CRTC through its processor interface (E, CSn, RS, RW, D). On `start` it writes a built-in 16-entry register table (R0–R15) using the two-step protocol: address-register write (RS=0), then data-register write (RS=1). Between sequences it grants single host register writes over a valid/ready handshake. It sits between the system bus/boot logic and the CRTC, and is the only driver of the CRTC processor pins.

## Interface
- `E_HALF`, default 2: number of CLK cycles E is held high per bus cycle (≥1).
- `NREGS`, default 16: number of table entries written by the init sequence (1–16).
- `CLK`  in  1: system clock; all logic is rising-edge.
- `RSTn`  in  1: reset, asynchronous, active-low.
- `start`  in  1: one-cycle request to run the init table; ignored while `busy`.
- `busy`  out  1: high from the cycle after `start` is accepted until `done`.
- `done`  out  1: one-cycle pulse after the last table write completes.
- `wr_valid`  in  1: host single-register write request.
- `wr_ready`  out  1: request accepted when `wr_valid && wr_ready`.
- `wr_addr`  in  5: host CRTC register index.
- `wr_data`  in  8: host register value.
- `E`  out  1: CRTC enable strobe; the CRTC samples on the falling edge.
- `CSn`  out  1: CRTC chip select, active-low.
- `RS`  out  1: 0 selects the address register, 1 selects the data register.
- `RW`  out  1: 0 = write; always 1 when idle.
- `D`  out  8: CRTC data bus; write-only in this block.

## Operation
- Reset values: E=0, CSn=1, RS=0, RW=1, D=8'h00, busy=0, done=0, wr_ready=0 during reset and 1 in IDLE afterwards.
- Bus FSM states and transitions:
  - IDLE → SETUP, on an accepted start or host write.
  - SETUP (1 clk) → EHIGH.
  - EHIGH (E_HALF clks) → HOLD.
  - HOLD (1 clk) → GAP.
  - GAP (1 clk) → SETUP for the next bus cycle, or IDLE when finished.
- Pin levels by state:
  - SETUP: CSn=0, RW=0, RS and D valid.
  - EHIGH: E=1.
  - HOLD: E=0; CSn, RS and D unchanged, giving hold time after the falling edge.
  - GAP: CSn=1, RW=1; D keeps its last value.
- Register write = two bus cycles.
  - Phase A: RS=0, D={3'b000, index}.
  - Phase B: RS=1, D=value.
- Init sequence:
  - Index counter runs 0..NREGS-1.
  - Each value is read from the table sub-module.
  - Counter increments after each Phase B GAP.
  - `done` pulses in the cycle the FSM enters IDLE after entry NREGS-1; `busy` drops in the same cycle.
- Host write:
  - The 5-bit `wr_addr` and `wr_data` are latched on acceptance and written as Phase A then Phase B.
  - Indices 16–31 are passed through unmodified. The CRTC ignores them; this block does not filter them.
- Arbitration:
  - `wr_ready` = IDLE && !start.
  - `start` and `wr_valid` in the same IDLE cycle: start wins and the host request waits.
  - Host writes never interleave with an init sequence. `busy` stays low during host writes.
- `start` during a host write: ignored. A requester retries after `wr_ready` returns.
- Reset mid-sequence:
  - Pins return to idle immediately (asynchronous).
  - Counter clears; no `done` pulse is produced.
  - The CRTC address register may hold a stale index; that is acceptable.

## Timing
- Bus cycle length: E_HALF+3 clks. Register write: 2·(E_HALF+3) clks (10 at the default).
- Init run: NREGS·2·(E_HALF+3) clks from the first SETUP (160 at the defaults).
- `done` fires 1 clk after the final GAP.
- Latency from accepted start/host write to first SETUP: 1 clk.
- D, RS and RW change only in SETUP (or GAP for RW). They are stable from SETUP through HOLD. CSn falls no later than RS/D become valid and rises after HOLD.
- Back-to-back host writes: the next acceptance is possible in the IDLE cycle after GAP, giving a minimum 11-clk spacing at the default.

## Structure
- Shared package `crtc_pkg` contains:
  - the bus-state enum (IDLE, SETUP, EHIGH, HOLD, GAP);
  - the phase enum (PH_ADDR, PH_DATA);
  - the CRTC register index constants R0..R17;
  - the MDA default table constants.
- Sub-module `crtc_init_rom`: combinational 4-bit index → 8-bit value, holding MDA defaults:
  - R0–R3: 61, 50, 52, 0F
  - R4–R7: 19, 06, 19, 19
  - R8–R11: 02, 0D, 0B, 0C
  - R12–R15: 00, 00, 00, 00

## Test plan
- Reset, then idle for 20 clks → E=0, CSn=1, RW=1, D=00 throughout; wr_ready=1; busy=0.
- Pulse start once → 32 bus cycles in 160 clks; decoded writes are R0=61, R1=50, … R9=0D, … R15=00; `done` pulses once at clk 161; an attached MS6845 model's AR ends at 0x0F.
- Idle host write addr=0x0E, data=0x3A → RS=0/D=0E cycle, then RS=1/D=3A cycle; E high 2 clks each; wr_ready low for 10 clks.
- start and wr_valid (addr 0x0A, data 0x20) in the same cycle → full init runs first; the host write is accepted the cycle after `done`, and R10 ends at 0x20.
- start pulsed again while busy, at entry 5 → ignored; still exactly 32 bus cycles and one `done`.
- RSTn low during EHIGH of entry 7 Phase B → pins go idle asynchronously; no `done`; a fresh start rewrites from R0.

Source files
------------

// File: rtl/crtc_pkg.sv
// crtc_pkg
//   Shared definitions for the MS6845 CRTC configuration sequencer:
//   bus-state and phase encodings, CRTC register indices R0..R17 and the
//   MDA power-up values written by the init sequence.
package crtc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        EHIGH = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } bus_state_e;

    typedef enum logic {
        PH_ADDR = 1'b0,
        PH_DATA = 1'b1
    } phase_e;

    localparam logic [4:0] R0  = 5'd0;
    localparam logic [4:0] R1  = 5'd1;
    localparam logic [4:0] R2  = 5'd2;
    localparam logic [4:0] R3  = 5'd3;
    localparam logic [4:0] R4  = 5'd4;
    localparam logic [4:0] R5  = 5'd5;
    localparam logic [4:0] R6  = 5'd6;
    localparam logic [4:0] R7  = 5'd7;
    localparam logic [4:0] R8  = 5'd8;
    localparam logic [4:0] R9  = 5'd9;
    localparam logic [4:0] R10 = 5'd10;
    localparam logic [4:0] R11 = 5'd11;
    localparam logic [4:0] R12 = 5'd12;
    localparam logic [4:0] R13 = 5'd13;
    localparam logic [4:0] R14 = 5'd14;
    localparam logic [4:0] R15 = 5'd15;
    localparam logic [4:0] R16 = 5'd16;
    localparam logic [4:0] R17 = 5'd17;

    localparam logic [7:0] MDA_R0  = 8'h61;
    localparam logic [7:0] MDA_R1  = 8'h50;
    localparam logic [7:0] MDA_R2  = 8'h52;
    localparam logic [7:0] MDA_R3  = 8'h0F;
    localparam logic [7:0] MDA_R4  = 8'h19;
    localparam logic [7:0] MDA_R5  = 8'h06;
    localparam logic [7:0] MDA_R6  = 8'h19;
    localparam logic [7:0] MDA_R7  = 8'h19;
    localparam logic [7:0] MDA_R8  = 8'h02;
    localparam logic [7:0] MDA_R9  = 8'h0D;
    localparam logic [7:0] MDA_R10 = 8'h0B;
    localparam logic [7:0] MDA_R11 = 8'h0C;
    localparam logic [7:0] MDA_R12 = 8'h00;
    localparam logic [7:0] MDA_R13 = 8'h00;
    localparam logic [7:0] MDA_R14 = 8'h00;
    localparam logic [7:0] MDA_R15 = 8'h00;

endpackage

// File: rtl/crtc_init_rom.sv
// crtc_init_rom
//   Combinational lookup of the MDA default value for CRTC registers R0..R15.
//   Ports:
//     idx_i  [3:0]  register index
//     val_o  [7:0]  default value for that register
module crtc_init_rom
    import crtc_pkg::*;
(
    input  logic [3:0] idx_i,
    output logic [7:0] val_o
);

    always_comb begin
        val_o = 8'h00;
        case (idx_i)
            4'd0:    val_o = MDA_R0;
            4'd1:    val_o = MDA_R1;
            4'd2:    val_o = MDA_R2;
            4'd3:    val_o = MDA_R3;
            4'd4:    val_o = MDA_R4;
            4'd5:    val_o = MDA_R5;
            4'd6:    val_o = MDA_R6;
            4'd7:    val_o = MDA_R7;
            4'd8:    val_o = MDA_R8;
            4'd9:    val_o = MDA_R9;
            4'd10:   val_o = MDA_R10;
            4'd11:   val_o = MDA_R11;
            4'd12:   val_o = MDA_R12;
            4'd13:   val_o = MDA_R13;
            4'd14:   val_o = MDA_R14;
            default: val_o = MDA_R15;
        endcase
    end

endmodule

// File: rtl/crtc_config_seq.sv
// crtc_config_seq
//   Sole bus master of the MS6845 CRTC processor interface. On start it
//   writes the MDA default table (R0..NREGS-1); when idle it grants single
//   host register writes. Every register write is an address-register bus
//   cycle (RS=0) followed by a data-register bus cycle (RS=1).
//
//   state | meaning
//   IDLE  | no bus activity, host writes may be granted
//   SETUP | CSn/RW low, RS and D driven (1 clk)
//   EHIGH | E high for E_HALF clks
//   HOLD  | E low, CSn/RS/D held after the falling edge (1 clk)
//   GAP   | CSn/RW high, next bus cycle or back to IDLE (1 clk)
//
//   Ports:
//     CLK, RSTn          clock, async active-low reset
//     start / busy, done init request, run status, completion pulse
//     wr_valid/wr_ready  host write handshake, wr_addr/wr_data payload
//     E, CSn, RS, RW, D  CRTC processor pins
module crtc_config_seq
    import crtc_pkg::*;
#(
    parameter int E_HALF = 2,
    parameter int NREGS  = 16
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       start,
    output logic       busy,
    output logic       done,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       E,
    output logic       CSn,
    output logic       RS,
    output logic       RW,
    output logic [7:0] D
);

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_SETUP = SETUP;
    localparam logic [2:0] ST_EHIGH = EHIGH;
    localparam logic [2:0] ST_HOLD  = HOLD;
    localparam logic [2:0] ST_GAP   = GAP;

    localparam logic [3:0] LAST_IDX  = 4'(NREGS - 1);
    localparam logic [7:0] ECNT_LOAD = 8'(E_HALF - 1);

    logic [2:0] state_q, state_d;
    phase_e     phase_q, phase_d;
    logic       init_q, init_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] hdata_q, hdata_d;
    logic       rs_q, rs_d;
    logic [7:0] dbus_q, dbus_d;
    logic [7:0] ecnt_q, ecnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    // Keeps wr_ready low while reset is held and for the first edge after it.
    logic       rdy_en_q;
    logic [7:0] rom_val;

    crtc_init_rom u_rom (
        .idx_i (idx_q),
        .val_o (rom_val)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        init_d  = init_q;
        idx_d   = idx_q;
        hdata_d = hdata_q;
        rs_d    = rs_q;
        dbus_d  = dbus_q;
        ecnt_d  = ecnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETUP;
                    init_d  = 1'b1;
                    busy_d  = 1'b1;
                    phase_d = PH_ADDR;
                    idx_d   = 4'd0;
                    rs_d    = 1'b0;
                    dbus_d  = 8'h00;
                end else if (wr_valid && wr_ready) begin
                    state_d = ST_SETUP;
                    init_d  = 1'b0;
                    phase_d = PH_ADDR;
                    hdata_d = wr_data;
                    rs_d    = 1'b0;
                    dbus_d  = {3'b000, wr_addr};
                end
            end
            ST_SETUP: begin
                state_d = ST_EHIGH;
                ecnt_d  = ECNT_LOAD;
            end
            ST_EHIGH: begin
                if (ecnt_q == 8'd0) begin
                    state_d = ST_HOLD;
                end else begin
                    ecnt_d = ecnt_q - 8'd1;
                end
            end
            ST_HOLD: state_d = ST_GAP;
            ST_GAP: begin
                if (phase_q == PH_ADDR) begin
                    state_d = ST_SETUP;
                    phase_d = PH_DATA;
                    rs_d    = 1'b1;
                    dbus_d  = init_q ? rom_val : hdata_q;
                end else if (init_q && (idx_q != LAST_IDX)) begin
                    state_d = ST_SETUP;
                    phase_d = PH_ADDR;
                    idx_d   = idx_q + 4'd1;
                    rs_d    = 1'b0;
                    dbus_d  = {4'b0000, idx_q + 4'd1};
                end else begin
                    state_d = ST_IDLE;
                    idx_d   = 4'd0;
                    init_d  = 1'b0;
                    if (init_q) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= ST_IDLE;
            phase_q  <= PH_ADDR;
            init_q   <= 1'b0;
            idx_q    <= 4'd0;
            hdata_q  <= 8'h00;
            rs_q     <= 1'b0;
            dbus_q   <= 8'h00;
            ecnt_q   <= 8'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            init_q   <= init_d;
            idx_q    <= idx_d;
            hdata_q  <= hdata_d;
            rs_q     <= rs_d;
            dbus_q   <= dbus_d;
            ecnt_q   <= ecnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rdy_en_q <= 1'b1;
        end
    end

    logic bus_act;
    assign bus_act  = (state_q == ST_SETUP) || (state_q == ST_EHIGH) || (state_q == ST_HOLD);

    assign E        = (state_q == ST_EHIGH);
    assign CSn      = !bus_act;
    assign RW       = !bus_act;
    assign RS       = rs_q;
    assign D        = dbus_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_ready = rdy_en_q && (state_q == ST_IDLE) && !start;

endmodule

// File: tb/tb_crtc_config_seq.sv
module tb_crtc_config_seq;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic       start;
    logic       busy, done;
    logic       wr_valid;
    logic       wr_ready;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       E, CSn, RS, RW;
    logic [7:0] D;

    always #5 CLK = ~CLK;

    crtc_config_seq #(.E_HALF(2), .NREGS(16)) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .E        (E),
        .CSn      (CSn),
        .RS       (RS),
        .RW       (RW),
        .D        (D)
    );

    // MS6845 processor-interface model: latches on the falling edge of E.
    typedef struct packed {
        logic       rs;
        logic [7:0] d;
    } wr_t;

    wr_t        log_q[$];
    logic [7:0] mregs [32];
    logic [4:0] mar;

    always @(negedge E) begin
        if (RSTn && !CSn && !RW) begin
            log_q.push_back({RS, D});
            if (!RS) mar <= D[4:0];
            else     mregs[mar] <= D;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [7:0] mda [16];
    wr_t        exp_init [32];

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
        logic [7:0] exp_da;
        logic [7:0] exp_db;
    } hvec_t;
    hvec_t hvec [3];

    task automatic run_init(input string nm, input int retrig);
        int   done_k, dcnt, first_cs;
        logic b1, busy_at_done;
        log_q.delete();
        done_k = -1; dcnt = 0; first_cs = -1; b1 = 1'b0; busy_at_done = 1'b1;
        @(negedge CLK);
        start = 1'b1;
        for (int k = 1; k <= 175; k++) begin
            @(negedge CLK);
            if (k == 1) b1 = busy;
            if (!CSn && first_cs < 0) first_cs = k;
            if (done) begin
                dcnt++;
                if (done_k < 0) begin
                    done_k       = k;
                    busy_at_done = busy;
                end
            end
            start = (k == retrig);
        end
        start = 1'b0;
        chk({nm, "_first_setup"}, first_cs, 1);
        chk({nm, "_busy_start"}, b1, 1);
        chk({nm, "_done_clk"}, done_k, 161);
        chk({nm, "_done_count"}, dcnt, 1);
        chk({nm, "_busy_at_done"}, busy_at_done, 0);
        chk({nm, "_bus_cycles"}, log_q.size(), 32);
        for (int i = 0; i < 32; i++)
            chk($sformatf("%s_wr%0d", nm, i), log_q[i], exp_init[i]);
        chk({nm, "_ar"}, mar, 5'h0F);
    endtask

    initial begin
        int   viol, lo, eh, acc_k, bseen, dcnt;
        logic saw_done;

        mda = '{8'h61, 8'h50, 8'h52, 8'h0F, 8'h19, 8'h06, 8'h19, 8'h19,
                8'h02, 8'h0D, 8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 16; i++) begin
            exp_init[2*i]     = '{rs: 1'b0, d: 8'(i)};
            exp_init[2*i + 1] = '{rs: 1'b1, d: mda[i]};
        end
        hvec[0] = '{addr: 5'h0E, data: 8'h3A, exp_da: 8'h0E, exp_db: 8'h3A};
        hvec[1] = '{addr: 5'h1F, data: 8'hFF, exp_da: 8'h1F, exp_db: 8'hFF};
        hvec[2] = '{addr: 5'h00, data: 8'h55, exp_da: 8'h00, exp_db: 8'h55};

        RSTn = 1'b0; start = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;

        // Reset and idle behaviour
        repeat (3) @(negedge CLK);
        chk("rst_pins", {E, CSn, RS, RW, D}, {1'b0, 1'b1, 1'b0, 1'b1, 8'h00});
        chk("rst_busy_done", {busy, done}, 2'b00);
        chk("rst_wr_ready", wr_ready, 0);
        RSTn = 1'b1;
        viol = 0;
        repeat (20) begin
            @(negedge CLK);
            if (E || !CSn || !RW || D != 8'h00 || busy || !wr_ready) viol++;
        end
        chk("idle_20clk", viol, 0);

        // Full init sequence
        run_init("init", 0);

        // Host writes, table-driven
        for (int v = 0; v < 3; v++) begin
            log_q.delete();
            @(negedge CLK);
            chk($sformatf("h%0d_ready", v), wr_ready, 1);
            wr_valid = 1'b1; wr_addr = hvec[v].addr; wr_data = hvec[v].data;
            @(negedge CLK);
            wr_valid = 1'b0;
            lo = 0; eh = 0; bseen = 0;
            for (int n = 0; n < 30 && !wr_ready; n++) begin
                lo++;
                if (E) eh++;
                if (busy) bseen = 1;
                @(negedge CLK);
            end
            chk($sformatf("h%0d_ready_low", v), lo, 10);
            chk($sformatf("h%0d_e_high", v), eh, 4);
            chk($sformatf("h%0d_busy", v), bseen, 0);
            chk($sformatf("h%0d_cycles", v), log_q.size(), 2);
            chk($sformatf("h%0d_phase_a", v), log_q[0], {1'b0, hvec[v].exp_da});
            chk($sformatf("h%0d_phase_b", v), log_q[1], {1'b1, hvec[v].exp_db});
            chk($sformatf("h%0d_reg", v), mregs[hvec[v].addr], hvec[v].data);
        end

        // start and wr_valid together: init first, host write right after done
        chk("r10_before", mregs[10], 8'h0B);
        log_q.delete();
        @(negedge CLK);
        start = 1'b1; wr_valid = 1'b1; wr_addr = 5'h0A; wr_data = 8'h20;
        acc_k = -1; saw_done = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge CLK);
            if (wr_ready) begin
                acc_k = k; saw_done = done;
                break;
            end
            start = 1'b0;
        end
        start = 1'b0;
        @(negedge CLK);
        wr_valid = 1'b0;
        for (int n = 0; n < 30 && !wr_ready; n++) @(negedge CLK);
        chk("arb_accept_clk", acc_k, 161);
        chk("arb_done_before", saw_done, 1);
        chk("arb_cycles", log_q.size(), 34);
        chk("arb_r10", mregs[10], 8'h20);

        // start while busy at entry 5 is ignored
        run_init("retrig", 55);

        // Reset during EHIGH of entry 7 phase B
        log_q.delete();
        @(negedge CLK);
        start = 1'b1;
        for (int k = 1; k <= 77; k++) begin
            @(negedge CLK);
            start = 1'b0;
        end
        chk("mid_e_high", E, 1);
        chk("mid_cycles_pre", log_q.size(), 15);
        #2 RSTn = 1'b0;
        #1;
        chk("mid_rst_pins", {E, CSn, RS, RW, D}, {1'b0, 1'b1, 1'b0, 1'b1, 8'h00});
        chk("mid_rst_busy", {busy, done, wr_ready}, 3'b000);
        @(negedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        dcnt = 0;
        repeat (200) begin
            @(negedge CLK);
            if (done) dcnt++;
        end
        chk("mid_no_done", dcnt, 0);
        chk("mid_cycles_post", log_q.size(), 15);
        run_init("after_rst", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
